// File: rtl/zircon_segled_pkg.sv
// Shared constants, state encoding and the hex-to-segment table for the
// Zircon six-digit seven-segment scan controller.
package zircon_segled_pkg;

  localparam int NUM_DIGITS = 6;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [5:0] SEL_OFF = 6'b111111;

  // Active-low segment patterns, bit7 (dp) held high so dp is off by default.
  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

endpackage

// File: rtl/zircon_segled_if.sv
// Bundle between the segment-LED register block (master) and the scan
// controller (slave): digit values, dp and enable in; selects, segments and
// the frame marker out.
// Handshake: there is none; digit inputs are level signals that may change
// at any time and are sampled once per slot, and the outputs are registered
// levels plus a one-cycle frame_start pulse.
interface zircon_segled_if;
  logic [3:0] seg_data1;
  logic [3:0] seg_data2;
  logic [3:0] seg_data3;
  logic [3:0] seg_data4;
  logic [3:0] seg_data5;
  logic [3:0] seg_data6;
  logic [5:0] seg_dp;
  logic [5:0] seg_en;
  logic [5:0] seg_sel;
  logic [7:0] seg_led;
  logic       frame_start;

  modport master (
    output seg_data1, seg_data2, seg_data3, seg_data4, seg_data5, seg_data6,
    output seg_dp, seg_en,
    input  seg_sel, seg_led, frame_start
  );

  modport slave (
    input  seg_data1, seg_data2, seg_data3, seg_data4, seg_data5, seg_data6,
    input  seg_dp, seg_en,
    output seg_sel, seg_led, frame_start
  );
endinterface

// File: rtl/zircon_segled_decode.sv
// Combinational hex-to-seven-segment decoder, active-low, with dp on bit7.
module zircon_segled_decode
  import zircon_segled_pkg::*;
(
  input  logic [3:0] val,
  input  logic       dp,
  output logic [7:0] seg
);

  // Table gives g..a; a lit decimal point pulls bit7 low.
  always_comb begin
    seg = {~dp, HEX_SEG[val][6:0]};
  end

endmodule

// File: rtl/zircon_segled_scan.sv
// Six-digit scan controller: slot counter, digit index and BLANK/SHOW FSM.
// Each slot starts blanked, snapshots its digit on the last blank cycle and
// then shows that snapshot, so software writes mid-slot never tear.
module zircon_segled_scan
  import zircon_segled_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic             csi_clk,
  input  logic             rsi_reset_n,
  zircon_segled_if.slave   bus,
  output state_e           dbg_state
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_SNAP = CW'(BLANK_CYCLES - 1);
  localparam logic [2:0]    DIG_LAST = 3'(NUM_DIGITS - 1);
  localparam logic [5:0]    SEL_ONE  = 6'b000001;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    dig_q, dig_d;
  logic [3:0]    snap_val_q, snap_val_d;
  logic          snap_dp_q, snap_dp_d;
  logic          snap_en_q, snap_en_d;
  logic [5:0]    sel_q, sel_d;
  logic [7:0]    led_q, led_d;
  logic          fs_q, fs_d;

  logic [3:0]    cur_val;
  logic [7:0]    dec_seg;

  // Select the live input value of the digit owning the current slot.
  always_comb begin
    cur_val = bus.seg_data1;
    case (dig_q)
      3'd0:    cur_val = bus.seg_data1;
      3'd1:    cur_val = bus.seg_data2;
      3'd2:    cur_val = bus.seg_data3;
      3'd3:    cur_val = bus.seg_data4;
      3'd4:    cur_val = bus.seg_data5;
      3'd5:    cur_val = bus.seg_data6;
      default: cur_val = bus.seg_data1;
    endcase
  end

  zircon_segled_decode u_decode (
    .val (snap_val_q),
    .dp  (snap_dp_q),
    .seg (dec_seg)
  );

  // Next-state for counter, digit, FSM and snapshot, plus the output image.
  always_comb begin
    cnt_d      = cnt_q + CW'(1);
    dig_d      = dig_q;
    state_d    = state_q;
    snap_val_d = snap_val_q;
    snap_dp_d  = snap_dp_q;
    snap_en_d  = snap_en_q;
    sel_d      = SEL_OFF;
    led_d      = SEG_OFF;
    fs_d       = 1'b0;

    // Last blank cycle: freeze this digit's inputs for the rest of the slot.
    if (cnt_q == CNT_SNAP) begin
      state_d    = SHOW;
      snap_val_d = cur_val;
      snap_dp_d  = bus.seg_dp[dig_q];
      snap_en_d  = bus.seg_en[dig_q];
    end

    // End of slot: wrap counter, advance digit, re-enter blanking.
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      dig_d   = (dig_q == DIG_LAST) ? 3'd0 : dig_q + 3'd1;
      state_d = BLANK;
    end

    // Outputs lag the counter state by one register stage.
    if (state_q == SHOW && snap_en_q) begin
      sel_d = ~(SEL_ONE << dig_q);
      led_d = dec_seg;
    end
    fs_d = (state_q == BLANK) && (cnt_q == '0) && (dig_q == 3'd0);
  end

  // State, snapshot and output registers; reset blanks the display at once.
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state_q    <= BLANK;
      cnt_q      <= '0;
      dig_q      <= 3'd0;
      snap_val_q <= 4'd0;
      snap_dp_q  <= 1'b0;
      snap_en_q  <= 1'b0;
      sel_q      <= SEL_OFF;
      led_q      <= SEG_OFF;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dig_q      <= dig_d;
      snap_val_q <= snap_val_d;
      snap_dp_q  <= snap_dp_d;
      snap_en_q  <= snap_en_d;
      sel_q      <= sel_d;
      led_q      <= led_d;
      fs_q       <= fs_d;
    end
  end

  assign bus.seg_sel     = sel_q;
  assign bus.seg_led     = led_q;
  assign bus.frame_start = fs_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_zircon_segled_scan.sv
// Bench for zircon_segled_scan with an 8-cycle slot and 2 blank cycles.
// The reference model works purely from the cycle count since reset release:
// frame position, slot offset and a per-digit snapshot array.
module tb_zircon_segled_scan;
  import zircon_segled_pkg::*;

  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 6 * SD;

  // ---------------- clock / reset ----------------
  logic csi_clk = 1'b0;
  logic rsi_reset_n = 1'b0;
  always #5 csi_clk = ~csi_clk;

  zircon_segled_if bus();
  state_e dbg_state;

  zircon_segled_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .csi_clk     (csi_clk),
    .rsi_reset_n (rsi_reset_n),
    .bus         (bus),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int k;
  int last_fs;
  logic [5:0] prev_sel;
  logic [3:0] m_val [6];
  logic       m_dp  [6];
  logic       m_en  [6];
  logic [7:0] exp_q [$];
  logic [7:0] hex_tbl [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at k=%0d: got %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [3:0] data_of(input int d);
    case (d)
      0: return bus.seg_data1;
      1: return bus.seg_data2;
      2: return bus.seg_data3;
      3: return bus.seg_data4;
      4: return bus.seg_data5;
      default: return bus.seg_data6;
    endcase
  endfunction

  task automatic set_data(input int d, input logic [3:0] v);
    case (d)
      0: bus.seg_data1 = v;
      1: bus.seg_data2 = v;
      2: bus.seg_data3 = v;
      3: bus.seg_data4 = v;
      4: bus.seg_data5 = v;
      default: bus.seg_data6 = v;
    endcase
  endtask

  task automatic model_reset();
    k = 0;
    last_fs = -1;
    prev_sel = 6'h3F;
    for (int i = 0; i < 6; i++) begin
      m_val[i] = 4'd0;
      m_dp[i]  = 1'b0;
      m_en[i]  = 1'b0;
    end
  endtask

  // ---------------- driver / model step ----------------
  // One clock: update the model at the edge, compare on the falling edge.
  task automatic step();
    int p, d, o;
    logic [5:0] one;
    logic [5:0] exp_sel;
    logic [7:0] exp_led;
    logic [7:0] tmp;
    @(posedge csi_clk);
    k++;
    p = (k - 1) % FRAME;
    d = p / SD;
    o = p % SD;
    if (o == BC - 1) begin
      m_val[d] = data_of(d);
      m_dp[d]  = bus.seg_dp[d];
      m_en[d]  = bus.seg_en[d];
    end
    @(negedge csi_clk);
    one = 6'b000001;
    exp_sel = 6'h3F;
    exp_led = 8'hFF;
    if (o >= BC && m_en[d]) begin
      exp_sel = ~(one << d);
      tmp = hex_tbl[m_val[d]];
      exp_led = {~m_dp[d], tmp[6:0]};
    end
    exp_q.push_back(exp_led);
    check("seg_sel", 32'(bus.seg_sel), 32'(exp_sel));
    check("seg_led", 32'(bus.seg_led), 32'(exp_q.pop_front()));
    check("frame_start", 32'(bus.frame_start), 32'(p == 0));
    check("sel_onehot", 32'($countones(~bus.seg_sel) <= 1), 32'd1);
    if (prev_sel != 6'h3F && bus.seg_sel != 6'h3F)
      check("sel_no_hop", 32'(bus.seg_sel), 32'(prev_sel));
    if (bus.frame_start) begin
      if (last_fs >= 0) check("fs_period", 32'(k - last_fs), 32'(FRAME));
      last_fs = k;
    end
    prev_sel = bus.seg_sel;
  endtask

  // Step until the frame position of the last output cycle equals target.
  task automatic step_to(input int target);
    for (int i = 0; i < FRAME; i++) begin
      step();
      if ((k - 1) % FRAME == target) return;
    end
    check("step_to_bound", 32'd0, 32'd1);
  endtask

  task automatic release_reset();
    @(negedge csi_clk);
    model_reset();
    rsi_reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    for (int i = 0; i < 6; i++) set_data(i, 4'(i));
    bus.seg_dp = 6'b000000;
    bus.seg_en = 6'b111111;

    // Reset held: display dark, no frame marker.
    repeat (3) @(negedge csi_clk);
    check("rst_sel", 32'(bus.seg_sel), 32'h3F);
    check("rst_led", 32'(bus.seg_led), 32'hFF);
    check("rst_fs", 32'(bus.frame_start), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(BLANK));

    // Full frame of 0..5.
    release_reset();
    step();
    check("first_fs", 32'(bus.frame_start), 32'd1);
    for (int i = 0; i < 2 * FRAME; i++) step();

    // Enable gaps and a lit dp on digit 0 showing 8.
    bus.seg_en = 6'b101101;
    bus.seg_dp = 6'b000001;
    bus.seg_data1 = 4'd8;
    step_to(FRAME - 1);
    step_to(4);
    check("dp_digit0", 32'(bus.seg_led), 32'h00);
    for (int i = 0; i < FRAME; i++) step();

    // No tearing: change digit 0 during its SHOW.
    bus.seg_en = 6'b111111;
    bus.seg_dp = 6'b000000;
    bus.seg_data1 = 4'd3;
    step_to(FRAME - 1);
    step_to(3);
    bus.seg_data1 = 4'hA;
    step_to(7);
    check("tear_hold", 32'(bus.seg_led), 32'hB0);
    step_to(2);
    check("tear_new", 32'(bus.seg_led), 32'h88);

    // Mid-slot reset during digit 3 SHOW; outputs drop with no clock edge.
    step_to(3 * SD + 3);
    #2 rsi_reset_n = 1'b0;
    #1;
    check("async_sel", 32'(bus.seg_sel), 32'h3F);
    check("async_led", 32'(bus.seg_led), 32'hFF);
    repeat (2) @(negedge csi_clk);
    check("async_state", 32'(dbg_state), 32'(BLANK));
    release_reset();
    step();
    check("restart_fs", 32'(bus.frame_start), 32'd1);
    step_to(BC);
    check("restart_sel", 32'(bus.seg_sel), 32'h3E);

    // Random traffic: inputs change at arbitrary points inside slots.
    for (int i = 0; i < 20 * FRAME; i++) begin
      if ($urandom_range(0, 7) == 0) set_data($urandom_range(0, 5), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 31) == 0) bus.seg_dp = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 31) == 0) bus.seg_en = 6'($urandom_range(0, 63));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
